// File: rtl/sram_like_bridge_pkg.sv
// Shared state and access-size encodings for the SRAM to SRAM-like bridge.
package sram_like_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StHold = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_like_bridge_wen_to_size.sv
// Byte-enable to SRAM-like access size encoder (purely combinational).
module sram_like_bridge_wen_to_size
  import sram_like_bridge_pkg::*;
#(
  parameter int unsigned WEN_W = 4
) (
  input  logic [WEN_W-1:0] i_wen,
  output logic [1:0]       o_size
);

  logic w_onehot;
  logic w_pair;

  always_comb begin
    w_onehot = 1'b0;
    w_pair   = 1'b0;
    for (int unsigned i = 0; i < WEN_W; i++) begin
      if (i_wen == (WEN_W'(1) << i)) w_onehot = 1'b1;
    end
    // Halfword only when the two enabled bytes form an aligned pair.
    for (int unsigned i = 0; i + 1 < WEN_W; i += 2) begin
      if (i_wen == (WEN_W'(3) << i)) w_pair = 1'b1;
    end
    if (w_onehot)    o_size = SZ_BYTE;
    else if (w_pair) o_size = SZ_HALF;
    else             o_size = SZ_WORD;
  end

endmodule

// File: rtl/sram_like_bridge.sv
// SRAM to SRAM-like (req/addr_ok/data_ok) bridge for one pipeline channel.
// Optional kseg0/kseg1 address map enabled by defining BRIDGE_KSEG_MAP_EN.
module sram_like_bridge
  import sram_like_bridge_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned WEN_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sram_en,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic [WEN_W-1:0]  sram_wen,
  input  logic [DATA_W-1:0] sram_wdata,
  input  logic [1:0]        sram_rsize,
  output logic [DATA_W-1:0] sram_rdata,
  output logic              stall,
  input  logic              flush,
  input  logic              longest_stall,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata
);

  state_e            r_state;
  state_e            w_state_next;
  logic              r_drop;
  logic              w_drop_next;
  logic [DATA_W-1:0] r_rdata;
  logic              w_capture;
  logic              w_req;
  logic [1:0]        w_wen_size;

  sram_like_bridge_wen_to_size #(
    .WEN_W(WEN_W)
  ) u_wen_to_size (
    .i_wen (sram_wen),
    .o_size(w_wen_size)
  );

  assign wr    = |sram_wen;
  assign size  = wr ? w_wen_size : sram_rsize;
  assign wdata = sram_wdata;

`ifdef BRIDGE_KSEG_MAP_EN
  always_comb begin
    addr = sram_addr;
    if (sram_addr[ADDR_W-1 -: 2] == 2'b10) addr[ADDR_W-1 -: 3] = 3'b000;
  end
`else
  assign addr = sram_addr;
`endif

  always_comb begin
    w_state_next = r_state;
    w_drop_next  = r_drop;
    w_capture    = 1'b0;
    w_req        = 1'b0;
    case (r_state)
      StIdle: begin
        if (sram_en && !flush) begin
          w_req        = 1'b1;
          w_state_next = addr_ok ? StWait : StReq;
        end
      end
      StReq: begin
        w_req = 1'b1;
        // An address accepted in the flush cycle is still outstanding: wait and discard it.
        if (addr_ok) begin
          w_state_next = StWait;
          if (flush) w_drop_next = 1'b1;
        end else if (flush) begin
          w_state_next = StIdle;
        end
      end
      StWait: begin
        if (flush) w_drop_next = 1'b1;
        if (data_ok) begin
          w_drop_next = 1'b0;
          if (r_drop || flush) begin
            w_state_next = StIdle;
          end else begin
            w_capture    = 1'b1;
            w_state_next = StHold;
          end
        end
      end
      StHold: begin
        if (flush || !longest_stall) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Gated by reset so the bus sees no request while the core is held in reset.
  assign req   = w_req & rst;
  assign stall = sram_en & ~flush & ~r_drop & (r_state != StHold) & rst;
  assign sram_rdata = r_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_drop  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_drop  <= w_drop_next;
      if (w_capture) r_rdata <= rdata;
    end
  end

endmodule

// File: tb/tb_sram_like_bridge.sv
// Self-checking bench for sram_like_bridge: read/write, hold, flush, back-pressure, reset.
module tb_sram_like_bridge;

  logic        clk;
  logic        rst;
  logic        sram_en;
  logic [31:0] sram_addr;
  logic [3:0]  sram_wen;
  logic [31:0] sram_wdata;
  logic [1:0]  sram_rsize;
  logic [31:0] sram_rdata;
  logic        stall;
  logic        flush;
  logic        longest_stall;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_issued = 0;
  int unsigned n_base;

  logic [66:0] bus_q[$];
  logic [31:0] rd_q[$];

  sram_like_bridge u_dut (
    .clk          (clk),
    .rst          (rst),
    .sram_en      (sram_en),
    .sram_addr    (sram_addr),
    .sram_wen     (sram_wen),
    .sram_wdata   (sram_wdata),
    .sram_rsize   (sram_rsize),
    .sram_rdata   (sram_rdata),
    .stall        (stall),
    .flush        (flush),
    .longest_stall(longest_stall),
    .req          (req),
    .wr           (wr),
    .size         (size),
    .addr         (addr),
    .wdata        (wdata),
    .addr_ok      (addr_ok),
    .data_ok      (data_ok),
    .rdata        (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push_bus(input logic [31:0] a, input logic w, input logic [1:0] s,
                          input logic [31:0] d);
    bus_q.push_back({a, w, s, d});
  endtask

  task automatic start_read(input logic [31:0] a, input logic [1:0] rs, input logic [31:0] d);
    sram_en    = 1'b1;
    sram_addr  = a;
    sram_wen   = 4'b0000;
    sram_rsize = rs;
    sram_wdata = 32'h0;
    push_bus(a, 1'b0, rs, 32'h0);
    rd_q.push_back(d);
  endtask

  task automatic pop_rd(input string tag);
    logic [31:0] e;
    if (rd_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = rd_q.pop_front();
      check_eq({tag, "_rdata"}, sram_rdata, e);
      check_eq({tag, "_stall"}, stall, 1'b0);
    end
  endtask

  // Bus-side scoreboard: every accepted request must match the next expected transaction.
  always @(negedge clk) begin
    logic [66:0] e;
    if (rst && req && addr_ok) begin
      n_issued++;
      if (bus_q.size() == 0) begin
        check_eq("bus_unexpected", 64'd1, 64'd0);
      end else begin
        e = bus_q.pop_front();
        check_eq("bus_addr", addr, e[66:35]);
        check_eq("bus_wr_size", {wr, size}, e[34:32]);
        check_eq("bus_wdata", wdata, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [3:0] wen_tab[7]  = '{4'b0001, 4'b1000, 4'b0011, 4'b1100, 4'b0110, 4'b1111, 4'b0111};
  logic [1:0] size_tab[7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};

  initial begin
    rst = 1'b0;
    sram_en = 1'b0; sram_addr = 32'h0; sram_wen = 4'h0; sram_wdata = 32'h0; sram_rsize = 2'd0;
    flush = 1'b0; longest_stall = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
    smp(); smp();
    check_eq("rst_req", req, 1'b0);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_rdata", sram_rdata, 32'h0);
    tick(); rst = 1'b1;

    // Minimum-latency read.
    tick(); start_read(32'h1000, 2'd2, 32'hDEADBEEF); addr_ok = 1'b1;
    smp(); check_eq("rd_c0_stall", stall, 1'b1); check_eq("rd_c0_req", req, 1'b1);
    tick(); addr_ok = 1'b0;
    smp(); check_eq("rd_c1_stall", stall, 1'b1); check_eq("rd_c1_req", req, 1'b0);
    tick(); data_ok = 1'b1; rdata = 32'hDEADBEEF;
    smp(); check_eq("rd_c2_stall", stall, 1'b1);
    tick(); data_ok = 1'b0; rdata = 32'h0;
    smp(); pop_rd("rd_c3");
    tick(); sram_en = 1'b0;
    smp(); check_eq("rd_idle_req", req, 1'b0);
    check_eq("rd_keep", sram_rdata, 32'hDEADBEEF);

    // Halfword write.
    tick(); sram_en = 1'b1; sram_addr = 32'h2002; sram_wen = 4'b0011; sram_wdata = 32'hCAFEF00D;
    push_bus(32'h2002, 1'b1, 2'd1, 32'hCAFEF00D);
    smp(); check_eq("wr_req", req, 1'b1); check_eq("wr_wr", wr, 1'b1);
    check_eq("wr_size", size, 2'd1); check_eq("wr_stall", stall, 1'b1);
    tick(); addr_ok = 1'b1;
    smp(); check_eq("wr_req_ok", req, 1'b1);
    tick(); addr_ok = 1'b0; data_ok = 1'b1;
    smp(); check_eq("wr_stall_dok", stall, 1'b1);
    tick(); data_ok = 1'b0;
    smp(); check_eq("wr_stall_done", stall, 1'b0);
    tick(); sram_en = 1'b0; sram_wen = 4'b0000; sram_wdata = 32'h0;

    // Hold while another channel stalls the pipeline.
    tick(); start_read(32'h3000, 2'd2, 32'h0BADF00D); addr_ok = 1'b1;
    smp();
    tick(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h0BADF00D;
    smp(); check_eq("hd_stall_dok", stall, 1'b1);
    tick(); data_ok = 1'b0; rdata = 32'h0; longest_stall = 1'b1;
    smp(); pop_rd("hd_first"); check_eq("hd_req0", req, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); smp();
      check_eq("hd_rdata", sram_rdata, 32'h0BADF00D);
      check_eq("hd_req", req, 1'b0);
      check_eq("hd_stall", stall, 1'b0);
    end
    tick(); longest_stall = 1'b0;
    smp(); check_eq("hd_fall_req", req, 1'b0);
    tick(); start_read(32'h3004, 2'd2, 32'h11112222); addr_ok = 1'b1;
    smp(); check_eq("hd_idle_req", req, 1'b1);
    tick(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h11112222;
    smp();
    tick(); data_ok = 1'b0; rdata = 32'h0;
    smp(); pop_rd("hd_next");
    tick(); sram_en = 1'b0;

    // Flush while waiting for data: the returned word is discarded.
    tick(); sram_en = 1'b1; sram_addr = 32'h4000; sram_wen = 4'b0000; sram_rsize = 2'd2;
    push_bus(32'h4000, 1'b0, 2'd2, 32'h0); addr_ok = 1'b1;
    smp(); check_eq("fl_req", req, 1'b1);
    tick(); addr_ok = 1'b0; flush = 1'b1;
    smp(); check_eq("fl_stall_f", stall, 1'b0); check_eq("fl_req_f", req, 1'b0);
    tick(); flush = 1'b0; sram_addr = 32'h5000;
    smp(); check_eq("fl_stall_drop", stall, 1'b0); check_eq("fl_req_drop", req, 1'b0);
    tick(); data_ok = 1'b1; rdata = 32'h12345678;
    smp(); check_eq("fl_stall_dok", stall, 1'b0); check_eq("fl_req_dok", req, 1'b0);
    tick(); data_ok = 1'b0; rdata = 32'h0; start_read(32'h5000, 2'd2, 32'h55556666);
    addr_ok = 1'b1;
    smp(); check_eq("fl_rdata_keep", sram_rdata, 32'h11112222);
    check_eq("fl_reissue", req, 1'b1);
    tick(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h55556666;
    smp();
    tick(); data_ok = 1'b0; rdata = 32'h0;
    smp(); pop_rd("fl_next");
    tick(); sram_en = 1'b0;

    // Back-pressure: address not accepted for 10 cycles.
    tick(); start_read(32'h6000, 2'd1, 32'h0000ABCD); n_base = n_issued;
    for (int i = 0; i < 10; i++) begin
      smp();
      check_eq("bp_req", req, 1'b1);
      check_eq("bp_addr", addr, 32'h6000);
      check_eq("bp_size", size, 2'd1);
      check_eq("bp_wdata", wdata, 32'h0);
      tick();
    end
    addr_ok = 1'b1;
    smp();
    tick(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h0000ABCD;
    smp();
    tick(); data_ok = 1'b0; rdata = 32'h0;
    smp(); pop_rd("bp_done");
    check_eq("bp_issued", n_issued - n_base, 64'd1);
    tick(); sram_en = 1'b0;

    // Byte-enable to size encoding.
    tick();
    for (int i = 0; i < 7; i++) begin
      sram_wen = wen_tab[i];
      #1;
      check_eq("wen_size", size, size_tab[i]);
      check_eq("wen_wr", wr, 1'b1);
    end
    sram_wen = 4'b0000;

    // Asynchronous reset while waiting for data.
    tick(); start_read(32'h7000, 2'd2, 32'h0); void'(rd_q.pop_back()); addr_ok = 1'b1;
    smp();
    tick(); addr_ok = 1'b0;
    #2; rst = 1'b0;
    #1;
    check_eq("ar_req", req, 1'b0);
    check_eq("ar_stall", stall, 1'b0);
    check_eq("ar_rdata", sram_rdata, 32'h0);
    tick(); sram_en = 1'b0; rst = 1'b1;

    // Address map.
    tick(); sram_addr = 32'hBFC0_0000;
    #1;
`ifdef BRIDGE_KSEG_MAP_EN
    check_eq("kseg_addr", addr, 32'h1FC0_0000);
`else
    check_eq("kseg_addr", addr, 32'hBFC0_0000);
`endif
    sram_addr = 32'h0040_0000;
    #1;
    check_eq("kuseg_addr", addr, 32'h0040_0000);

    smp();
    check_eq("sb_rd_left", rd_q.size(), 64'd0);
    check_eq("sb_bus_left", bus_q.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
